// File: rtl/processor_help.sv
// Shared processor types and constants used by the front-end.
package processor_help;

  localparam int SUPER_SCALAR_WIDTH = 2;
  localparam int WORD_WIDTH         = 32;
  localparam int ADDR_WIDTH         = 32;

  typedef logic [WORD_WIDTH-1:0] Word;
  typedef logic [ADDR_WIDTH-1:0] Addr;
  typedef Word [SUPER_SCALAR_WIDTH-1:0] FetchBundle;

  function automatic Addr next_bundle_pc(input Addr pc);
    return pc + Addr'(SUPER_SCALAR_WIDTH);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with a registered head, count/full/empty and a flush
// that drops every buffered entry in one cycle.
module fetch_queue
  import processor_help::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(FetchBundle),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    tail_ptr;
  logic [CW-1:0]    count_q;
  logic             do_enq;
  logic             do_deq;

  assign do_enq = enq && !flush;
  assign do_deq = deq && !flush && !empty;

  // Storage is cleared on reset so the head reads as zeros before the first fill.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head_ptr <= tail_ptr;
      count_q  <= '0;
    end else begin
      if (do_enq) begin
        mem[tail_ptr] <= enq_data;
        tail_ptr      <= tail_ptr + PW'(1);
      end
      if (do_deq) head_ptr <= head_ptr + PW'(1);
      count_q <= count_q + CW'(do_enq) - CW'(do_deq);
    end
  end

  assign head  = mem[head_ptr];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch.sv
// Fetch stage: PC, credit-limited bundle requests, response queue and redirect flush.
// Optional FETCH_PC_TRACE_EN adds decode_pc_out carrying the head bundle's word address.
module fetch
  import processor_help::*;
#(
  parameter int  QUEUE_DEPTH = 4,
  parameter Addr RESET_PC    = '0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  output logic       mem_req_valid_out,
  input  logic       mem_req_ready_in,
  output Addr        mem_req_addr_out,
  input  logic       mem_resp_valid_in,
  input  FetchBundle mem_resp_data_in,
  input  logic       redirect_valid_in,
  input  Addr        redirect_pc_in,
  input  logic       decode_ready_in,
  output logic       decode_valid_out,
`ifdef FETCH_PC_TRACE_EN
  output Addr        decode_pc_out,
`endif
  output FetchBundle decode_data_out
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int BW = $bits(FetchBundle);
`ifdef FETCH_PC_TRACE_EN
  localparam int QW = BW + ADDR_WIDTH;
`else
  localparam int QW = BW;
`endif

  Addr           pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic [QW-1:0] q_head;
  logic [QW-1:0] q_enq_data;
  logic [CW:0]   in_use;
  logic          credit_ok;
  logic          req_fire;
  logic          resp_drop;
  logic          resp_keep;
  logic          dequeue;

  assign in_use    = {1'b0, q_count} + {1'b0, outstanding};
  assign credit_ok = in_use < (CW+1)'(QUEUE_DEPTH);

  assign mem_req_valid_out = rst_n_in && !redirect_valid_in && credit_ok;
  assign mem_req_addr_out  = pc;
  assign req_fire          = mem_req_valid_out && mem_req_ready_in;

  assign resp_drop = mem_resp_valid_in && (redirect_valid_in || (discard != '0));
  assign resp_keep = mem_resp_valid_in && !resp_drop;

  assign decode_valid_out = !q_empty && !redirect_valid_in;
  assign dequeue          = decode_valid_out && decode_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(mem_resp_valid_in);
      if (redirect_valid_in) begin
        pc      <= redirect_pc_in;
        // outstanding already includes responses still owed to discard, so the
        // new discard is simply whatever remains in flight after this cycle.
        discard <= outstanding - CW'(mem_resp_valid_in);
      end else begin
        if (req_fire)  pc      <= next_bundle_pc(pc);
        if (resp_drop) discard <= discard - CW'(1);
      end
    end
  end

`ifdef FETCH_PC_TRACE_EN
  Addr           pc_fifo_head;
  logic [CW-1:0] pc_fifo_count;
  logic          pc_fifo_full;
  logic          pc_fifo_empty;

  // PCs of in-flight kept requests; discarded responses never pop it because it is
  // flushed together with the main queue on redirect.
  fetch_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(ADDR_WIDTH)) u_pc_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .enq      (req_fire),
    .enq_data (pc),
    .deq      (resp_keep),
    .flush    (redirect_valid_in),
    .head     (pc_fifo_head),
    .count    (pc_fifo_count),
    .full     (pc_fifo_full),
    .empty    (pc_fifo_empty)
  );

  assign q_enq_data    = {pc_fifo_head, mem_resp_data_in};
  assign decode_pc_out = q_head[QW-1:BW];

  a_pc_fifo_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(req_fire && pc_fifo_full));
  a_pc_fifo_no_underflow: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(resp_keep && pc_fifo_empty));
  a_pc_fifo_tracks_kept: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    pc_fifo_count == (outstanding - discard));
`else
  assign q_enq_data = mem_resp_data_in;
`endif

  fetch_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(QW)) u_queue (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .enq      (resp_keep),
    .enq_data (q_enq_data),
    .deq      (dequeue),
    .flush    (redirect_valid_in),
    .head     (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign decode_data_out = q_head[BW-1:0];

  a_no_resp_when_full: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(mem_resp_valid_in && q_full));

endmodule

// File: tb/tb_fetch.sv
// Directed table-driven bench for fetch with a one-cycle-latency memory model.
module tb_fetch;
  import processor_help::*;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b1;
  logic       mem_req_valid_out;
  logic       mem_req_ready_in;
  Addr        mem_req_addr_out;
  logic       mem_resp_valid_in;
  FetchBundle mem_resp_data_in;
  logic       redirect_valid_in;
  Addr        redirect_pc_in;
  logic       decode_ready_in;
  logic       decode_valid_out;
  FetchBundle decode_data_out;
`ifdef FETCH_PC_TRACE_EN
  Addr        decode_pc_out;
`endif

  always #5 clk_in = ~clk_in;

  fetch #(.QUEUE_DEPTH(4), .RESET_PC('0)) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .mem_req_valid_out (mem_req_valid_out),
    .mem_req_ready_in  (mem_req_ready_in),
    .mem_req_addr_out  (mem_req_addr_out),
    .mem_resp_valid_in (mem_resp_valid_in),
    .mem_resp_data_in  (mem_resp_data_in),
    .redirect_valid_in (redirect_valid_in),
    .redirect_pc_in    (redirect_pc_in),
    .decode_ready_in   (decode_ready_in),
    .decode_valid_out  (decode_valid_out),
`ifdef FETCH_PC_TRACE_EN
    .decode_pc_out     (decode_pc_out),
`endif
    .decode_data_out   (decode_data_out)
  );

  // rst: pulse reset before the row; dr: decode ready; rd/rpc: redirect; mr: mem ready;
  // re: memory may respond; ev/ea: expected request; dv/da: expected head bundle address.
  typedef struct {
    bit  rst;
    bit  dr;
    bit  rd;
    Addr rpc;
    bit  mr;
    bit  re;
    bit  ev;
    Addr ea;
    bit  dv;
    Addr da;
  } vec_t;

  vec_t vecs[$];
  Addr  pipe[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic FetchBundle mk_bundle(input Addr a);
    FetchBundle b;
    for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) b[i] = Word'(a + Addr'(i)) ^ 32'hC0DE_0000;
    return b;
  endfunction

  function automatic vec_t mk(input bit rst, input bit dr, input bit rd, input Addr rpc,
                              input bit mr, input bit re, input bit ev, input Addr ea,
                              input bit dv, input Addr da);
    vec_t v;
    v.rst = rst; v.dr = dr; v.rd = rd; v.rpc = rpc; v.mr = mr;
    v.re = re; v.ev = ev; v.ea = ea; v.dv = dv; v.da = da;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    mem_req_ready_in  = 1'b0;
    mem_resp_valid_in = 1'b0;
    mem_resp_data_in  = '0;
    redirect_valid_in = 1'b0;
    redirect_pc_in    = '0;
    decode_ready_in   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    drive_idle();
    pipe.delete();
    #1;
    chk("rst_req_valid", mem_req_valid_out, 1'b0);
    chk("rst_dec_valid", decode_valid_out, 1'b0);
    chk("rst_dec_data", decode_data_out, '0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    if (v.rst) do_reset();
    @(negedge clk_in);
    decode_ready_in   = v.dr;
    redirect_valid_in = v.rd;
    redirect_pc_in    = v.rpc;
    mem_req_ready_in  = v.mr;
    if (v.re && pipe.size() > 0) begin
      mem_resp_valid_in = 1'b1;
      mem_resp_data_in  = mk_bundle(pipe.pop_front());
    end else begin
      mem_resp_valid_in = 1'b0;
      mem_resp_data_in  = '0;
    end
    #1;
    chk($sformatf("req_valid[%0d]", idx), mem_req_valid_out, v.ev);
    if (v.ev) chk($sformatf("req_addr[%0d]", idx), mem_req_addr_out, v.ea);
    chk($sformatf("dec_valid[%0d]", idx), decode_valid_out, v.dv);
    if (v.dv) begin
      chk($sformatf("dec_data[%0d]", idx), decode_data_out, mk_bundle(v.da));
`ifdef FETCH_PC_TRACE_EN
      chk($sformatf("dec_pc[%0d]", idx), decode_pc_out, v.da);
`endif
    end
    if (mem_req_valid_out && mem_req_ready_in) pipe.push_back(mem_req_addr_out);
  endtask

  initial begin
    drive_idle();

    // streaming: requests 0,2,4,... and bundles after a 2-cycle fill
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 1, 'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h4, 1, 'h0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h6, 1, 'h2));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h8, 1, 'h4));
    // decode stalled: exactly four requests, then credit exhausted; release drains
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h4, 1, 'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h6, 1, 'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 'h0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 1, 'h0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h8, 1, 'h2));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'hA, 1, 'h4));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'hC, 1, 'h6));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'hE, 1, 'h8));
    // redirect to 0x40 with 3 outstanding and 1 queued: three responses dropped
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 'h2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 'h6, 1, 'h0));
    vecs.push_back(mk(0, 1, 1, 'h40, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h40, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h42, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h44, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h46, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 1, 'h40));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h48, 1, 'h42));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h4A, 1, 'h44));
    // redirect coinciding with a response and decode ready
    vecs.push_back(mk(0, 1, 1, 'h100, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h100, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h102, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h104, 1, 'h100));
    // back-to-back redirects: the later target wins
    vecs.push_back(mk(0, 1, 1, 'h200, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 'h300, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h300, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h302, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h304, 1, 'h300));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 'h306, 1, 'h302));

    for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);

    // asynchronous reset between clock edges, mid-stream
    @(negedge clk_in);
    drive_idle();
    #1;
    chk("pre_rst_dec_valid", decode_valid_out, 1'b1);
    chk("pre_rst_req_valid", mem_req_valid_out, 1'b1);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("async_rst_req_valid", mem_req_valid_out, 1'b0);
    chk("async_rst_dec_valid", decode_valid_out, 1'b0);
    chk("async_rst_dec_data", decode_data_out, '0);
    pipe.delete();
    @(posedge clk_in);
    #1;
    chk("held_rst_req_valid", mem_req_valid_out, 1'b0);
    @(negedge clk_in);
    rst_n_in         = 1'b1;
    decode_ready_in  = 1'b1;
    mem_req_ready_in = 1'b1;
    #1;
    chk("post_rst_req_valid", mem_req_valid_out, 1'b1);
    chk("post_rst_req_addr", mem_req_addr_out, '0);
    if (mem_req_valid_out && mem_req_ready_in) pipe.push_back(mem_req_addr_out);
    run_row(mk(0, 1, 0, 0, 1, 1, 1, 'h2, 0, 0), 100);
    run_row(mk(0, 1, 0, 0, 1, 1, 1, 'h4, 1, 'h0), 101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
